// File: rtl/dram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port DRAM with asynchronous read.
// Each transaction runs IDLE -> SERVE -> DONE; acks and read data are registered.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; dram_a/dram_d hold their last values
// SERVE | granted address/data on the DRAM, dram_we high for writes
// DONE  | granted master's ack high, read data already captured
module dram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              m0_req,
  input  logic              m0_wen,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wen,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] dram_a,
  output logic              dram_we,
  output logic [DATA_W-1:0] dram_d,
  input  logic [DATA_W-1:0] dram_spo,
  output logic              busy,
  output logic              gnt_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_last;
  logic                r_wen;
  logic                r_m0_ack;
  logic                r_m1_ack;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;
  logic [ADDR_W-1:0]   r_dram_a;
  logic                r_dram_we;
  logic [DATA_W-1:0]   r_dram_d;
  logic                r_busy;
  logic                r_gnt_id;

  logic                w_any;
  logic                w_win_id;
  logic                w_win_wen;
  logic [31:0]         w_win_addr;
  logic [DATA_W-1:0]   w_win_wdata;
  logic                w_unused;

  // On a tie the master that did not win last time gets the grant.
  assign w_any       = m0_req | m1_req;
  assign w_win_id    = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_win_wen   = w_win_id ? m1_wen   : m0_wen;
  assign w_win_addr  = w_win_id ? m1_addr  : m0_addr;
  assign w_win_wdata = w_win_id ? m1_wdata : m0_wdata;

  // Byte-lane and out-of-range address bits are deliberately dropped.
  assign w_unused = ^{w_win_addr[31:ADDR_W+2], w_win_addr[1:0]};

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_wen      <= 1'b0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_dram_a   <= '0;
      r_dram_we  <= 1'b0;
      r_dram_d   <= '0;
      r_busy     <= 1'b0;
      r_gnt_id   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state   <= S_SERVE;
            r_busy    <= 1'b1;
            r_gnt_id  <= w_win_id;
            r_last    <= w_win_id;
            r_wen     <= w_win_wen;
            r_dram_we <= w_win_wen;
            r_dram_a  <= w_win_addr[ADDR_W+1:2];
            r_dram_d  <= w_win_wdata;
          end
        end
        S_SERVE: begin
          r_state   <= S_DONE;
          r_dram_we <= 1'b0;
          if (!r_wen) begin
            if (r_gnt_id) r_m1_rdata <= dram_spo;
            else          r_m0_rdata <= dram_spo;
          end
          if (r_gnt_id) r_m1_ack <= 1'b1;
          else          r_m0_ack <= 1'b1;
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_dram_we <= 1'b0;
          r_m0_ack  <= 1'b0;
          r_m1_ack  <= 1'b0;
        end
      endcase
    end
  end

  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;
  assign dram_a   = r_dram_a;
  assign dram_we  = r_dram_we;
  assign dram_d   = r_dram_d;
  assign busy     = r_busy;
  assign gnt_id   = r_gnt_id;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: behavioural DRAM, table of single transactions,
// and a scoreboard of expected acks checked by a negedge monitor.
module tb_dram_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              cpu_clk = 1'b0;
  logic              cpu_rst;
  logic              m0_req, m0_wen, m1_req, m1_wen;
  logic [31:0]       m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_ack, m1_ack;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] dram_a;
  logic              dram_we;
  logic [DATA_W-1:0] dram_d;
  logic [DATA_W-1:0] dram_spo;
  logic              busy, gnt_id;

  dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .dram_a(dram_a), .dram_we(dram_we), .dram_d(dram_d), .dram_spo(dram_spo),
    .busy(busy), .gnt_id(gnt_id)
  );

  always #5 cpu_clk = ~cpu_clk;

  // DRAM: asynchronous read, write on the clock edge while dram_we is high
  logic [DATA_W-1:0] dram_mem [0:DEPTH-1];
  logic [DATA_W-1:0] exp_mem  [0:DEPTH-1];
  assign dram_spo = dram_mem[dram_a];
  always @(posedge cpu_clk) if (dram_we) dram_mem[dram_a] <= dram_d;

  int cyc = 0;
  always @(posedge cpu_clk) cyc++;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    bit                id;
    bit                rd;
    logic [DATA_W-1:0] data;
  } sb_t;

  sb_t               sb_q [$];
  logic [DATA_W-1:0] model_rd [2];
  int                ack_cnt [2];
  int                ack_cyc [2];

  // Scoreboard monitor: every ack must match the oldest outstanding expectation.
  always @(negedge cpu_clk) begin : monitor
    sb_t e;
    bit  id;
    chk("one_ack", {31'd0, m0_ack & m1_ack}, 32'd0);
    if (m0_ack ^ m1_ack) begin
      id = m1_ack;
      ack_cnt[id]++;
      ack_cyc[id] = cyc;
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_empty: ack from m%0d with no outstanding request (cycle %0d)", id, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("ack_id", {31'd0, id}, {31'd0, e.id});
        if (e.rd) model_rd[e.id] = e.data;
        chk("m0_rdata", m0_rdata, model_rd[0]);
        chk("m1_rdata", m1_rdata, model_rd[1]);
      end
    end
  end

  task automatic push(input bit id, input bit wen, input logic [ADDR_W-1:0] wa,
                      input logic [DATA_W-1:0] wdata);
    sb_t e;
    e.id = id;
    e.rd = !wen;
    e.data = '0;
    if (wen) exp_mem[wa] = wdata;
    else     e.data = exp_mem[wa];
    sb_q.push_back(e);
  endtask

  task automatic drive(input bit id, input bit wen, input logic [31:0] addr,
                       input logic [DATA_W-1:0] wdata);
    if (id) begin
      m1_req = 1'b1; m1_wen = wen; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_wen = wen; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
    chk("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
    chk("rst_dram_we", {31'd0, dram_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gnt_id", {31'd0, gnt_id}, 32'd0);
    chk("rst_dram_a", {18'd0, dram_a}, 32'd0);
    chk("rst_dram_d", dram_d, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
  endtask

  typedef struct {
    bit                id;
    bit                wen;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] exp_a;
  } vec_t;

  vec_t vecs [7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      dram_mem[i] = 32'hA5A5_0000 ^ i;
      exp_mem[i]  = 32'hA5A5_0000 ^ i;
    end
    model_rd[0] = '0; model_rd[1] = '0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    ack_cyc[0] = 0; ack_cyc[1] = 0;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 14'h0004};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 14'h0004};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0024, 32'hCAFEF00D, 14'h0009};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0024, 32'h0000_0000, 14'h0009};
    vecs[4] = '{1'b0, 1'b0, 32'h0001_FFFF, 32'h0000_0000, 14'h3FFF};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_0102, 32'h0000_0000, 14'h0040};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0003, 32'h1111_2222, 14'h0000};

    cpu_rst = 1'b0;
    m0_req = 0; m0_wen = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wen = 0; m1_addr = '0; m1_wdata = '0;
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk_reset_state();
    cpu_rst = 1'b1;

    // single transactions, req dropped during SERVE every time
    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].id, vecs[v].wen, vecs[v].addr, vecs[v].wdata);
      push(vecs[v].id, vecs[v].wen, vecs[v].exp_a, vecs[v].wdata);
      @(posedge cpu_clk); @(negedge cpu_clk);
      m0_req = 1'b0; m1_req = 1'b0;
      chk("serve_busy", {31'd0, busy}, 32'd1);
      chk("serve_gnt", {31'd0, gnt_id}, {31'd0, vecs[v].id});
      chk("serve_a", {18'd0, dram_a}, {18'd0, vecs[v].exp_a});
      chk("serve_we", {31'd0, dram_we}, {31'd0, vecs[v].wen});
      if (vecs[v].wen) chk("serve_d", dram_d, vecs[v].wdata);
      @(posedge cpu_clk); @(negedge cpu_clk);
      chk("done_ack", {31'd0, vecs[v].id ? m1_ack : m0_ack}, 32'd1);
      chk("done_we", {31'd0, dram_we}, 32'd0);
      chk("done_busy", {31'd0, busy}, 32'd1);
      @(posedge cpu_clk); @(negedge cpu_clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
      chk("idle_a_hold", {18'd0, dram_a}, {18'd0, vecs[v].exp_a});
    end

    // reset during SERVE of an m1 write aborts it without an ack
    drive(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
    @(posedge cpu_clk); @(negedge cpu_clk);
    m1_req = 1'b0;
    chk("abort_serve_we", {31'd0, dram_we}, 32'd1);
    cpu_rst = 1'b0;
    @(posedge cpu_clk); @(negedge cpu_clk);
    exp_mem[14'h0010] = 32'h1234_5678;
    model_rd[0] = '0; model_rd[1] = '0;
    chk_reset_state();
    @(posedge cpu_clk); @(negedge cpu_clk);
    chk("abort_no_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    cpu_rst = 1'b1;
    @(posedge cpu_clk); @(negedge cpu_clk);

    // simultaneous requests after reset: m0 first, m1 three cycles later
    drive(1'b0, 1'b0, 32'h0000_0010, '0);
    drive(1'b1, 1'b0, 32'h0000_0024, '0);
    push(1'b0, 1'b0, 14'h0004, '0);
    push(1'b1, 1'b0, 14'h0009, '0);
    @(posedge cpu_clk); @(negedge cpu_clk);
    chk("tie_gnt_first", {31'd0, gnt_id}, 32'd0);
    m0_req = 1'b0;
    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk("tie_gnt_second", {31'd0, gnt_id}, 32'd1);
    m1_req = 1'b0;
    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk("tie_ack_gap", ack_cyc[1] - ack_cyc[0], 32'd3);

    // both requests held for 24 cycles: strict alternation, 4 acks each
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    drive(1'b0, 1'b0, 32'h0001_FFFF, '0);
    drive(1'b1, 1'b0, 32'h0000_0024, '0);
    for (int k = 0; k < 8; k++) push(k[0], 1'b0, k[0] ? 14'h0009 : 14'h3FFF, '0);
    repeat (24) @(posedge cpu_clk);
    @(negedge cpu_clk);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (4) @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk("rr_m0_acks", ack_cnt[0], 32'd4);
    chk("rr_m1_acks", ack_cnt[1], 32'd4);
    chk("sb_drained", sb_q.size(), 32'd0);
    chk("rr_m0_rdata", m0_rdata, 32'hA5A5_0000 ^ 32'h3FFF);
    chk("rr_m1_rdata", m1_rdata, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
